// File: rtl/dmem_ctrl.sv
// Byte-addressed, big-endian data memory behind a valid/ready request port with wait states and range checks.
// Define DMEM_ALIGN_CHECK_EN to also reject misaligned half/word accesses.
module dmem_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_BYTES = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);
  localparam int IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q;
  logic              cap_we, cap_signed;
  logic [1:0]        cap_size;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;

  logic [7:0] mem [DEPTH_BYTES];

  // With zero wait states the commit edge is the accepting edge, so the live inputs are used there.
  logic              t_we, t_signed, t_err, commit;
  logic [1:0]        t_size;
  logic [ADDR_W-1:0] t_addr;
  logic [DATA_W-1:0] t_wdata, load_data;
  logic [2:0]        nbytes;
  logic [ADDR_W:0]   last_addr;
  logic [IDX_W-1:0]  b0, b1, b2, b3;

  assign t_we     = (state_q == IDLE) ? req_we     : cap_we;
  assign t_signed = (state_q == IDLE) ? req_signed : cap_signed;
  assign t_size   = (state_q == IDLE) ? req_size   : cap_size;
  assign t_addr   = (state_q == IDLE) ? req_addr   : cap_addr;
  assign t_wdata  = (state_q == IDLE) ? req_wdata  : cap_wdata;

  // NOTE: every variable gets a default at the top of the block so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_d = (WAIT_STATES == 0) ? RESP : WAIT;
      end
      WAIT:    if (cnt_q == 4'd1) state_d = RESP;
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    unique case (t_size)
      2'd0:    nbytes = 3'd1;
      2'd1:    nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    // One extra bit catches address wrap-around past the top of the ADDR_W space.
    last_addr = {1'b0, t_addr} + (ADDR_W+1)'(nbytes) - (ADDR_W+1)'(1);
    t_err = (t_size == 2'd3) | last_addr[ADDR_W]
          | (last_addr >= (ADDR_W+1)'(DEPTH_BYTES));
`ifdef DMEM_ALIGN_CHECK_EN
    if ((t_size == 2'd1 && t_addr[0]) || (t_size == 2'd2 && t_addr[1:0] != 2'b00))
      t_err = 1'b1;
`endif
  end

  assign b0 = t_addr[IDX_W-1:0];
  assign b1 = b0 + IDX_W'(1);
  assign b2 = b0 + IDX_W'(2);
  assign b3 = b0 + IDX_W'(3);

  // Lowest address is the most significant byte of the unit.
  always_comb begin
    unique case (t_size)
      2'd0:    load_data = {{24{t_signed & mem[b0][7]}}, mem[b0]};
      2'd1:    load_data = {{16{t_signed & mem[b0][7]}}, mem[b0], mem[b1]};
      default: load_data = {mem[b0], mem[b1], mem[b2], mem[b3]};
    endcase
  end

  assign commit = rst && (state_d == RESP) && (state_q != RESP);

  // NOTE: storage deliberately has no reset so it can map onto a plain RAM.
  always_ff @(posedge clk) begin
    if (commit && t_we && !t_err) begin
      unique case (t_size)
        2'd0: mem[b0] <= t_wdata[7:0];
        2'd1: begin
          mem[b0] <= t_wdata[15:8];
          mem[b1] <= t_wdata[7:0];
        end
        default: begin
          mem[b0] <= t_wdata[31:24];
          mem[b1] <= t_wdata[23:16];
          mem[b2] <= t_wdata[15:8];
          mem[b3] <= t_wdata[7:0];
        end
      endcase
    end
  end

  // NOTE: registers use non-blocking assignments so all of them sample pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= 4'd0;
      cap_we     <= 1'b0;
      cap_signed <= 1'b0;
      cap_size   <= 2'd0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (state_q == IDLE && req_valid) begin
        cnt_q      <= 4'(WAIT_STATES);
        cap_we     <= req_we;
        cap_signed <= req_signed;
        cap_size   <= req_size;
        cap_addr   <= req_addr;
        cap_wdata  <= req_wdata;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (commit) begin
        resp_err   <= t_err;
        resp_rdata <= (t_err || t_we) ? '0 : load_data;
      end
    end
  end
endmodule
